// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle restoring divider (div_unit).
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Iteration counter must hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    localparam int unsigned DIV_CNT_W = cnt_width(DIV_WIDTH);

    localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUO = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem, quo} left, trial-subtract divisor.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_trial;
    logic           w_neg;

    assign w_rem_sh = {i_rem, i_quo[WIDTH-1]};
    // rem < divisor keeps rem_sh below 2*divisor, so bit WIDTH of the
    // WIDTH+1-bit difference is exactly the sign of the trial.
    assign w_trial  = w_rem_sh - {1'b0, i_divisor};
    assign w_neg    = w_trial[WIDTH];

    assign o_rem = w_neg ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], ~w_neg};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider feeding HI (remainder) / LO (quotient) bus registers.
// Optional signed division is enabled by defining DIV_SIGNED_EN.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             Yin,
    input  logic             start,
`ifdef DIV_SIGNED_EN
    input  logic             div_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dbz;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_sgn;
    logic             w_y_neg;
    logic             w_d_neg;
    logic [WIDTH-1:0] w_y_mag;
    logic [WIDTH-1:0] w_d_mag;
    logic [WIDTH-1:0] w_nrem;
    logic [WIDTH-1:0] w_nquo;
    logic [WIDTH-1:0] w_fin_rem;
    logic [WIDTH-1:0] w_fin_quo;

`ifdef DIV_SIGNED_EN
    assign w_sgn = div_signed;
`else
    assign w_sgn = 1'b0;
`endif

    // Divide magnitudes; signs are reapplied on the final write so latency is unchanged.
    assign w_y_neg = w_sgn & r_y[WIDTH-1];
    assign w_d_neg = w_sgn & bus_in[WIDTH-1];
    assign w_y_mag = w_y_neg ? -r_y : r_y;
    assign w_d_mag = w_d_neg ? -bus_in : bus_in;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (r_rem),
        .i_quo    (r_quo),
        .i_divisor(r_div),
        .o_rem    (w_nrem),
        .o_quo    (w_nquo)
    );

    assign w_fin_rem = r_neg_r ? -w_nrem : w_nrem;
    assign w_fin_quo = r_neg_q ? -w_nquo : w_nquo;

    always_ff @(posedge clk) begin
        if (!clear) begin
            r_state <= IDLE;
            r_y     <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (bus_in == '0) begin
                            r_hi   <= r_y;
                            r_lo   <= '1;
                            r_dbz  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_div   <= w_d_mag;
                            r_rem   <= '0;
                            r_quo   <= w_y_mag;
                            r_cnt   <= CW'(WIDTH);
                            r_neg_q <= w_y_neg ^ w_d_neg;
                            r_neg_r <= w_y_neg;
                            r_dbz   <= 1'b0;
                            r_state <= RUN;
                        end
                    end else if (Yin) begin
                        r_y <= bus_in;
                    end
                end
                RUN: begin
                    r_rem <= w_nrem;
                    r_quo <= w_nquo;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_hi    <= w_fin_rem;
                        r_lo    <= w_fin_quo;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = (r_state == RUN);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi_out      = r_hi;
    assign lo_out      = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// Directed scoreboard bench for div_unit (unsigned default build; signed cases under DIV_SIGNED_EN).
module tb_div_unit;
    import div_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         clear;
    logic [W-1:0] bus_in;
    logic         yin;
    logic         start;
    logic         sgn;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    always #5 clk = ~clk;

    div_unit #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .bus_in     (bus_in),
        .Yin        (yin),
        .start      (start),
`ifdef DIV_SIGNED_EN
        .div_signed (sgn),
`endif
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] y_model;
    int           checks   = 0;
    int           failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] y, input logic [W-1:0] d, input logic s);
        exp_t e;
        logic eff_s;
`ifdef DIV_SIGNED_EN
        eff_s = s;
`else
        eff_s = 1'b0;
`endif
        e.dbz = 1'b0;
        e.lat = 32;
        if (d == 0) begin
            e.lo  = DIV_DBZ_QUO;
            e.hi  = y;
            e.dbz = 1'b1;
            e.lat = 0;
        end else if (eff_s) begin
            if (y == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
                e.lo = 32'h8000_0000;
                e.hi = 32'h0;
            end else begin
                e.lo = W'($signed(y) / $signed(d));
                e.hi = W'($signed(y) % $signed(d));
            end
        end else begin
            e.lo = y / d;
            e.hi = y % d;
        end
        return e;
    endfunction

    task automatic load_y(input logic [W-1:0] v);
        yin    = 1'b1;
        bus_in = v;
        step();
        yin     = 1'b0;
        y_model = v;
    endtask

    task automatic issue(input logic [W-1:0] d, input logic s);
        sb.push_back(model(y_model, d, s));
        start  = 1'b1;
        bus_in = d;
        sgn    = s;
        step();
        start  = 1'b0;
        sgn    = 1'b0;
        bus_in = $urandom;
        if (d != 0) chk("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    // elapsed: edges already stepped since the start edge
    task automatic wait_result(input string tag, input int elapsed);
        exp_t e;
        int   n = elapsed;
        while (done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_sb_nonempty"}, {31'b0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_latency"}, W'(n), W'(e.lat));
            chk({tag, "_lo"}, lo_out, e.lo);
            chk({tag, "_hi"}, hi_out, e.hi);
            chk({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, e.dbz});
        end
        step();
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int done_seen;
        clear  = 1'b0;
        yin    = 1'b0;
        start  = 1'b0;
        sgn    = 1'b0;
        bus_in = '0;
        y_model = '0;
        step();
        step();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_lo", lo_out, 32'd0);
        clear = 1'b1;
        step();

        load_y(32'd100);
        issue(32'd7, 1'b0);
        wait_result("d100_7", 0);

        load_y(32'hFFFF_FFFF);
        issue(32'd1, 1'b0);
        wait_result("dmax_1", 0);

        load_y(32'd3);
        issue(32'hFFFF_FFFF, 1'b0);
        wait_result("d3_max", 0);

        load_y(32'd5);
        issue(32'd0, 1'b0);
        wait_result("d5_0", 0);
        chk("dbz_sticky", {31'b0, div_by_zero}, 32'd1);
        load_y(32'd100);
        issue(32'd7, 1'b0);
        chk("dbz_cleared", {31'b0, div_by_zero}, 32'd0);
        wait_result("d100_7b", 0);

        // start and Yin during RUN must be ignored
        issue(32'd7, 1'b0);
        repeat (9) step();
        start  = 1'b1;
        bus_in = 32'd3;
        step();
        start  = 1'b0;
        yin    = 1'b1;
        bus_in = 32'd9;
        step();
        yin = 1'b0;
        chk("run_busy_held", {31'b0, busy}, 32'd1);
        wait_result("ignored", 11);
        issue(32'd9, 1'b0);
        wait_result("keepy_100_9", 0);

        // abort by clear mid-division
        issue(32'd7, 1'b0);
        void'(sb.pop_back());
        repeat (9) step();
        clear = 1'b0;
        step();
        clear = 1'b1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi_out, 32'd0);
        chk("abort_lo", lo_out, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_seen++;
            step();
        end
        chk("abort_no_done", W'(done_seen), 32'd0);

        // same-cycle Yin+start uses previously latched Y
        load_y(32'd50);
        sb.push_back(model(y_model, 32'd4, 1'b0));
        yin    = 1'b1;
        start  = 1'b1;
        bus_in = 32'd4;
        step();
        yin   = 1'b0;
        start = 1'b0;
        wait_result("same_cycle", 0);

        load_y(32'hFFFF_FFF9);
        issue(32'd2, 1'b1);
        wait_result("neg7_2", 0);

`ifdef DIV_SIGNED_EN
        load_y(32'h8000_0000);
        issue(32'hFFFF_FFFF, 1'b1);
        wait_result("sovf", 0);
        load_y(32'd7);
        issue(32'hFFFF_FFFE, 1'b1);
        wait_result("s7_neg2", 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
